// File: rtl/arm_mc_controller_if.sv
// arm_mc_controller_if: instruction/flag inputs and datapath control outputs of the multicycle controller.
// master is the controller side, slave is the datapath side.
interface arm_mc_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Illegal;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Illegal,
        output ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Illegal,
        input  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM-subset control FSM with MEMLAT extra wait cycles per memory access.
// Define ARM_MC_SHIFT_EN to decode cmd 1101 as MOV with LSL/LSR by immediate.
module arm_mc_controller #(
    parameter int MEMLAT = 0
) (
    input  logic                clk,
    input  logic                reset,
    arm_mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [2:0] LAT = 3'(MEMLAT);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;
    logic [1:0] op;
    logic [2:0] alu_dp;
    logic       last, rd15, exec, cond_base, cond_ex, dp_ok, no_write, illegal, unused_ok;

    assign op        = bus.Instr[27:26];
    assign rd15      = &bus.Instr[15:12];
    assign last      = wait_q == LAT;
    assign exec      = state_q == EXECR || state_q == EXECI;
    assign unused_ok = ^{bus.Instr[19:16], bus.Instr[11:0]};
    assign bus.RegSrc = {op == 2'b01 && !bus.Instr[20], op == 2'b10};

    // flags_q is {N,Z,C,V}; odd condition codes invert the even one, 111x is always
    always_comb begin
        case (bus.Instr[31:29])
            3'b000:  cond_base = flags_q[2];
            3'b001:  cond_base = flags_q[1];
            3'b010:  cond_base = flags_q[3];
            3'b011:  cond_base = flags_q[0];
            3'b100:  cond_base = flags_q[1] & ~flags_q[2];
            3'b101:  cond_base = flags_q[3] ~^ flags_q[0];
            3'b110:  cond_base = ~flags_q[2] & (flags_q[3] ~^ flags_q[0]);
            default: cond_base = 1'b1;
        endcase
        cond_ex = bus.Instr[31:29] == 3'b111 || (cond_base ^ bus.Instr[28]);
    end

    always_comb begin
        alu_dp   = 3'b000;
        dp_ok    = 1'b1;
        no_write = 1'b0;
        case (bus.Instr[24:21])
            4'b0100: alu_dp = 3'b000;
            4'b0010: alu_dp = 3'b001;
            4'b0000: alu_dp = 3'b010;
            4'b1100: alu_dp = 3'b011;
            4'b1010: begin alu_dp = 3'b001; no_write = 1'b1; end
            4'b1000: begin alu_dp = 3'b010; no_write = 1'b1; end
`ifdef ARM_MC_SHIFT_EN
            4'b1101: begin alu_dp = {2'b10, bus.Instr[5]}; dp_ok = ~bus.Instr[6]; end
`endif
            default: dp_ok = 1'b0;
        endcase
    end

    assign illegal = bus.Instr[31:28] == 4'hF || op == 2'b11 || (op == 2'b00 && !dp_ok);
    assign cond_d  = state_q == DECODE ? cond_ex : cond_q;

    // C tracks arithmetic and shifter carry; V only arithmetic
    always_comb begin
        flags_d = flags_q;
        if (exec && bus.Instr[20] && cond_q) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            flags_d[1]   = (alu_dp[2] || !alu_dp[1]) ? bus.ALUFlags[1] : flags_q[1];
            flags_d[0]   = alu_dp[2:1] == 2'b00 ? bus.ALUFlags[0] : flags_q[0];
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = 3'd0;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.Illegal    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.ALUControl = 3'b000;
        case (state_q)
            FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = last;
                bus.PCWrite   = last;
                wait_d        = last ? 3'd0 : wait_q + 3'd1;
                state_d       = last ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.Illegal   = illegal;
                state_d       = illegal ? FETCH : op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH :
                                bus.Instr[25] ? EXECI : EXECR;
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 2'b01;
                state_d     = bus.Instr[20] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.AdrSrc = 1'b1;
                wait_d     = last ? 3'd0 : wait_q + 3'd1;
                state_d    = last ? MEMWB : MEMRD;
            end
            MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = cond_q && last;
                wait_d       = last ? 3'd0 : wait_q + 3'd1;
                state_d      = last ? FETCH : MEMWR;
            end
            MEMWB: begin
                bus.RegWrite  = cond_q;
                bus.PCWrite   = cond_q && rd15;
                bus.ResultSrc = 2'b01;
                state_d       = FETCH;
            end
            EXECR, EXECI: begin
                bus.ALUSrcB    = state_q == EXECI ? 2'b01 : 2'b00;
                bus.ALUControl = alu_dp;
                state_d        = no_write ? FETCH : ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = cond_q;
                bus.PCWrite  = cond_q && rd15;
                state_d      = FETCH;
            end
            BRANCH: begin
                bus.PCWrite   = cond_q;
                bus.ImmSrc    = 2'b10;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (reset) {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.Illegal} = 5'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= 3'd0;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: random and directed instruction streams on MEMLAT=0 and MEMLAT=2 controllers,
// compared per cycle against an instruction-level model of the control sequence.
module tb_arm_mc_controller;
    typedef struct packed {
        logic       pcw, irw, rw, mw, adr, srca;
        logic [1:0] res, srcb, imm;
        logic [2:0] alu;
        logic       ill;
    } ctl_t;

    logic        clk = 1'b0, rst0 = 1'b1, rst2 = 1'b1, sel = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  aluf = 4'h0, flags_m = 4'h0;
    int          lat = 0, checks = 0, errors = 0;
    ctl_t        obs;
    logic [1:0]  obs_regsrc;

    arm_mc_controller_if if0 ();
    arm_mc_controller_if if2 ();

    arm_mc_controller #(.MEMLAT(0)) dut0 (.clk(clk), .reset(rst0), .bus(if0));
    arm_mc_controller #(.MEMLAT(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2));

    assign if0.Instr = instr;
    assign if2.Instr = instr;
    assign if0.ALUFlags = aluf;
    assign if2.ALUFlags = aluf;
    assign obs = sel ?
        {if2.PCWrite, if2.IRWrite, if2.RegWrite, if2.MemWrite, if2.AdrSrc, if2.ALUSrcA,
         if2.ResultSrc, if2.ALUSrcB, if2.ImmSrc, if2.ALUControl, if2.Illegal} :
        {if0.PCWrite, if0.IRWrite, if0.RegWrite, if0.MemWrite, if0.AdrSrc, if0.ALUSrcA,
         if0.ResultSrc, if0.ALUSrcB, if0.ImmSrc, if0.ALUControl, if0.Illegal};
    assign obs_regsrc = sel ? if2.RegSrc : if0.RegSrc;

    always #5 clk = ~clk;

    function automatic ctl_t mk(input logic pcw, irw, rw, mw, adr, srca,
                                input logic [1:0] res, srcb, imm, input logic [2:0] alu, input logic ill);
        return {pcw, irw, rw, mw, adr, srca, res, srcb, imm, alu, ill};
    endfunction

    // ARM condition table, flags as {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && n == v;
            4'd13:   return z || n != v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [3:0]  cmds [10];
        cmds = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA, 4'h8, 4'hD, 4'hD, 4'h1, 4'hF};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[31:28] = 4'($urandom_range(0, 14));
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
                r[27:26] = 2'b00;
                r[24:21] = cmds[$urandom_range(0, 9)];
                r[6]     = $urandom_range(0, 3) == 0;
            end
            5, 6:    r[27:26] = 2'b01;
            7:       r[27:26] = 2'b10;
            8:       r[27:26] = 2'b11;
            default: ;
        endcase
        if ($urandom_range(0, 4) == 0) r[15:12] = 4'hF;
        return r;
    endfunction

    // Plans the whole expected control sequence of one instruction, then drives and compares it cycle by cycle
    task automatic run(input logic [31:0] ins, input logic [3:0] ef, input string tag);
        ctl_t       q[$];
        string      nm[$];
        logic [1:0] op;
        logic [2:0] a;
        logic       c, nw, ok, bad, ld, rd15;
        op = ins[27:26];
        ld = ins[20];
        rd15 = ins[15:12] == 4'hF;
        c = cond_pass(ins[31:28], flags_m);
        a = 3'd0;
        nw = 1'b0;
        ok = 1'b1;
        case (ins[24:21])
            4'b0100: a = 3'd0;
            4'b0010: a = 3'd1;
            4'b0000: a = 3'd2;
            4'b1100: a = 3'd3;
            4'b1010: begin a = 3'd1; nw = 1'b1; end
            4'b1000: begin a = 3'd2; nw = 1'b1; end
`ifdef ARM_MC_SHIFT_EN
            4'b1101: begin a = ins[6:5] == 2'b00 ? 3'd4 : 3'd5; ok = !ins[6]; end
`endif
            default: ok = 1'b0;
        endcase
        bad = ins[31:28] == 4'hF || op == 2'b11 || (op == 2'b00 && !ok);
        for (int k = 0; k <= lat; k++) begin
            q.push_back(mk(k == lat, k == lat, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 3'd0, 0));
            nm.push_back("FETCH");
        end
        q.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 3'd0, bad));
        nm.push_back("DECODE");
        if (!bad && op == 2'b01) begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0));
            nm.push_back("MEMADR");
            for (int k = 0; k <= lat; k++) begin
                q.push_back(mk(0, 0, 0, !ld && c && k == lat, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
                nm.push_back(ld ? "MEMRD" : "MEMWR");
            end
            if (ld) begin
                q.push_back(mk(c && rd15, 0, c, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 0));
                nm.push_back("MEMWB");
            end
        end else if (!bad && op == 2'b10) begin
            q.push_back(mk(c, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 3'd0, 0));
            nm.push_back("BRANCH");
        end else if (!bad) begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, ins[25] ? 2'd1 : 2'd0, 2'd0, a, 0));
            nm.push_back("EXEC");
            if (!nw) begin
                q.push_back(mk(c && rd15, 0, c, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
                nm.push_back("ALUWB");
            end
        end
        foreach (q[i]) begin
            @(negedge clk);
            instr = ins;
            aluf = nm[i] == "EXEC" ? ef : 4'($urandom);
            #1;
            chk($sformatf("%s %s[%0d] instr=%h", tag, nm[i], i, ins), 32'(obs), 32'(q[i]));
            if (nm[i] == "DECODE")
                chk($sformatf("%s RegSrc", tag), 32'(obs_regsrc), 32'({op == 2'b01 && !ld, op == 2'b10}));
        end
        if (!bad && op == 2'b00 && c && ins[20]) begin
            flags_m[3:2] = ef[3:2];
            if (a <= 3'd1) flags_m[1:0] = ef[1:0];
            if (a >= 3'd4) flags_m[1] = ef[1];
        end
    endtask

    initial begin
        #1;
        chk("reset0", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 3'd0, 0)));
        @(posedge clk);
        #1 rst0 = 1'b0;
        run(32'hE2801005, 4'($urandom), "add_imm");
        run(32'hE3510005, 4'b0110, "cmp_eq");
        run(32'h0A000001, 4'($urandom), "beq_taken");
        run(32'h02911001, 4'b0000, "addeqs_clear_z");
        run(32'hE3510005, 4'b0010, "cmp_ne");
        run(32'h0A000001, 4'($urandom), "beq_not_taken");
        run(32'hF0000000, 4'($urandom), "illegal_cond");
        run(32'hE1A01102, 4'($urandom), "lsl_imm");
        run(32'hE5802008, 4'($urandom), "str");
        run(32'hE590F008, 4'($urandom), "ldr_pc");
        instr = 32'hE280F005;
        repeat (4) @(negedge clk);
        rst0 = 1'b1;
        #1;
        chk("mid_reset_writes", 32'({obs.pcw, obs.irw, obs.rw, obs.mw, obs.ill}), 32'h0);
        @(posedge clk);
        #1 rst0 = 1'b0;
        flags_m = 4'h0;
        run(32'h0A000001, 4'($urandom), "beq_after_reset");
        for (int n = 0; n < 200; n++) run(rnd_instr(), 4'($urandom), "rnd0");
        rst0 = 1'b1;
        sel = 1'b1;
        lat = 2;
        flags_m = 4'h0;
        #1;
        chk("reset2", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 3'd0, 0)));
        @(posedge clk);
        #1 rst2 = 1'b0;
        run(32'hE5902008, 4'($urandom), "ldr_lat2");
        run(32'hE5802008, 4'($urandom), "str_lat2");
        run(32'hE2801005, 4'($urandom), "add_lat2");
        for (int n = 0; n < 200; n++) run(rnd_instr(), 4'($urandom), "rnd2");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
